dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//  Downstream consumer of the dotProduct operand memories (vector A RAM, vector B RAM).
//  On start, issues one shared read address per cycle to both RAMs and absorbs their 1-cycle read latency.
//  Multiply-accumulates signed element pairs into a full-width result.
//  Presents the result on a valid/ready output handshake.
// PARAMETERS
//  ADDR_WIDTH  4                          operand RAM address width; max vector length 2**ADDR_WIDTH
//  DATA_WIDTH  8                          operand element width, signed two's complement
//  ACC_WIDTH   2*DATA_WIDTH+ADDR_WIDTH    accumulator/result width; sized so it never overflows
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst_n         in   1             reset, synchronous, active-high (reset when rst_n==1)
//  start         in   1             request a new dot product; sampled only in IDLE
//  len           in   ADDR_WIDTH+1  element count, latched on accepted start
//  base_addr     in   ADDR_WIDTH    first element address, latched on accepted start
//  busy          out  1             high in every state except IDLE
//  rd_en         out  1             read enable to both RAMs (registered)
//  rd_addr       out  ADDR_WIDTH    shared read address to both RAMs (registered)
//  a_data        in   DATA_WIDTH    RAM A data_out, valid the cycle after rd_en
//  b_data        in   DATA_WIDTH    RAM B data_out, valid the cycle after rd_en
//  result        out  ACC_WIDTH     signed sum of a[i]*b[i]
//  result_valid  out  1             result available
//  result_ready  in   1             downstream accepts result
// BEHAVIOUR
//  Reset: state=IDLE; busy, rd_en, result_valid = 0; rd_addr, result, accumulator, index = 0.
//   Reset overrides everything, including mid-operation; the aborted job produces no result.
//  FSM states: IDLE -> FETCH -> DRAIN -> OUT -> IDLE.
//  IDLE
//   start=1 and len!=0: latch len (clamped to 2**ADDR_WIDTH if larger) and base_addr;
//    clear accumulator; go to FETCH.
//   start=1 and len==0: result=0; go to OUT.
//  FETCH: one cycle per element, rd_en=1, rd_addr=(base_addr+idx) mod 2**ADDR_WIDTH, idx=0..len-1.
//   After the cycle issuing idx=len-1, go to DRAIN.
//  Accumulate: a data-valid flag = rd_en delayed by 1 cycle; while it is set,
//   acc <= acc + sext(a_data)*sext(b_data).
//   Both operands are signed; the product is 2*DATA_WIDTH bits wide, sign-extended to ACC_WIDTH.
//  DRAIN: rd_en=0; absorbs the final element's product; go to OUT.
//  OUT: result=acc, result_valid=1. result is stable while result_valid=1 and result_ready=0.
//   result_valid=1 and result_ready=1: clear result_valid the next cycle and go to IDLE.
//  Latency: start sampled at edge E. First rd_en is seen in the cycle after E.
//   result_valid rises len+2 cycles after E; for len==0, 1 cycle after E.
//  start while busy=1 is ignored; no queuing.
//  Back-to-back jobs: start is accepted in the IDLE cycle right after the handshake,
//   giving 1 bubble cycle per job.
//  rd_addr wraps modulo 2**ADDR_WIDTH (base_addr+idx overflow is dropped).
// TESTING
//  T1: A[0..3]={1,2,3,4}, B[0..3]={5,6,7,8}, base=0, len=4, ready=1
//      -> result=70; result_valid exactly 6 cycles after start; rd_en high 4 cycles.
//  T2: A={-128,-128}, B={-128,127}, len=2 -> result=128 (16384-16256); checks signed math.
//  T3: len=16, all A=B=-128 -> result=262144, no overflow; len=20 -> clamped, same 16 reads.
//  T4: base=14, len=4 -> rd_addr sequence 14,15,0,1; result matches the wrapped elements.
//  T5: result_ready held low 5 cycles -> result and result_valid stable throughout.
//      start pulsed during the wait is ignored; len=0 start -> result=0 one cycle later.
//  T6: rst_n=1 in the 2nd FETCH cycle -> next cycle rd_en=0, busy=0, no result_valid.
//      A fresh len=4 job then gives the T1 result.

Source files
------------

// File: rtl/dot_product_engine.sv
// Streams element pairs from the A/B operand RAMs, multiply-accumulates them as signed
// values and offers the full-width sum on a valid/ready handshake.
module dot_product_engine #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     idx;
    logic [ADDR_WIDTH:0]     idx_nxt;
    logic                    last;
    logic                    data_valid;
    logic [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;

    assign idx_nxt  = idx + ONE;
    assign last     = (idx == len_q - ONE);
    assign prod     = $signed(a_data) * $signed(b_data);
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? FETCH : OUT;
            FETCH:   if (last) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (result_valid && result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // result is captured one cycle into OUT, after DRAIN's final accumulate has landed.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            len_q        <= '0;
            base_q       <= '0;
            idx          <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            data_valid   <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            data_valid <= rd_en;
            if (data_valid) acc <= acc + prod_ext;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= (len > MAX_LEN) ? MAX_LEN : len;
                        base_q <= base_addr;
                        idx    <= '0;
                        acc    <= '0;
                        if (len != '0) begin
                            rd_en   <= 1'b1;
                            rd_addr <= base_addr;
                        end
                    end
                end
                FETCH: begin
                    if (last) begin
                        rd_en <= 1'b0;
                    end else begin
                        idx     <= idx_nxt;
                        rd_addr <= base_q + idx_nxt[ADDR_WIDTH-1:0];
                    end
                end
                OUT: begin
                    if (!result_valid) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with behavioural 1-cycle-latency operand RAMs.
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic [3:0]  base_addr = '0;
    logic        busy;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  a_data = '0;
    logic [7:0]  b_data = '0;
    logic [19:0] result;
    logic        result_valid;
    logic        result_ready = 1'b1;

    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];
    logic [3:0]  addr_log [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc;
    int          rd_cnt;

    dot_product_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .base_addr(base_addr),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launches a job and waits (bounded) for result_valid; cyc = edges after the start edge.
    task automatic run_job(input logic [3:0] b, input logic [4:0] n);
        addr_log.delete();
        rd_cnt = 0;
        @(negedge clk);
        start = 1'b1; len = n; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!result_valid && cyc < 100) begin
            if (rd_en) begin
                rd_cnt++;
                addr_log.push_back(rd_addr);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 100) chk("timeout_waiting_result_valid", 32'(cyc), 32'd0);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_cleared"}, 32'(result_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3; mem_a[3] = 8'd4;
        mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7; mem_b[3] = 8'd8;
    endtask

    initial begin
        logic [3:0] exp_addr [4];

        load_t1();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_result_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // T1: basic 4-element job, latency and read count
        run_job(4'd0, 5'd4);
        chk("t1_result", 32'(result), 32'd70);
        chk("t1_latency", 32'(cyc), 32'd6);
        chk("t1_rd_cycles", 32'(rd_cnt), 32'd4);
        handshake("t1");

        // T2: signed extremes
        mem_a[0] = 8'h80; mem_a[1] = 8'h80;
        mem_b[0] = 8'h80; mem_b[1] = 8'h7f;
        run_job(4'd0, 5'd2);
        chk("t2_result", 32'(result), 32'd128);
        chk("t2_latency", 32'(cyc), 32'd4);
        handshake("t2");

        // T3: full length, then over-length request clamped
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h80;
            mem_b[i] = 8'h80;
        end
        run_job(4'd0, 5'd16);
        chk("t3_result_len16", 32'(result), 32'd262144);
        chk("t3_rd_cycles_len16", 32'(rd_cnt), 32'd16);
        chk("t3_latency_len16", 32'(cyc), 32'd18);
        handshake("t3a");
        run_job(4'd0, 5'd20);
        chk("t3_result_len20", 32'(result), 32'd262144);
        chk("t3_rd_cycles_len20", 32'(rd_cnt), 32'd16);
        chk("t3_latency_len20", 32'(cyc), 32'd18);
        handshake("t3b");

        // T4: address wrap 14,15,0,1 -> 2*10 + (-3)*7 + 4*(-1) + 5*3 = 10
        mem_a[14] = 8'd2;  mem_b[14] = 8'd10;
        mem_a[15] = 8'hfd; mem_b[15] = 8'd7;
        mem_a[0]  = 8'd4;  mem_b[0]  = 8'hff;
        mem_a[1]  = 8'd5;  mem_b[1]  = 8'd3;
        exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
        run_job(4'd14, 5'd4);
        chk("t4_result", 32'(result), 32'd10);
        chk("t4_rd_cycles", 32'(rd_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_rd_addr%0d", i),
                (addr_log.size() > i) ? 32'(addr_log[i]) : 32'hffff_ffff, 32'(exp_addr[i]));
        handshake("t4");

        // T5: backpressure with an ignored start, then a zero-length job
        load_t1();
        result_ready = 1'b0;
        run_job(4'd0, 5'd4);
        chk("t5_result", 32'(result), 32'd70);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            len = 5'd2;
            @(posedge clk); #1;
            chk($sformatf("t5_hold_valid%0d", i), 32'(result_valid), 32'd1);
            chk($sformatf("t5_hold_result%0d", i), 32'(result), 32'd70);
            chk($sformatf("t5_hold_no_read%0d", i), 32'(rd_en), 32'd0);
        end
        start = 1'b0;
        handshake("t5");
        run_job(4'd3, 5'd0);
        chk("t5_len0_result", 32'(result), 32'd0);
        chk("t5_len0_latency", 32'(cyc), 32'd1);
        chk("t5_len0_rd_cycles", 32'(rd_cnt), 32'd0);
        handshake("t5_len0");

        // T6: reset during the second fetch cycle aborts the job
        @(negedge clk);
        start = 1'b1; len = 5'd4; base_addr = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("t6_rd_en_after_reset", 32'(rd_en), 32'd0);
        chk("t6_busy_after_reset", 32'(busy), 32'd0);
        chk("t6_valid_after_reset", 32'(result_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_late_result", 32'(result_valid), 32'd0);
        run_job(4'd0, 5'd4);
        chk("t6_fresh_result", 32'(result), 32'd70);
        chk("t6_fresh_latency", 32'(cyc), 32'd6);
        handshake("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
